// File: rtl/usb_unstuff_deser.sv
// USB RX unstuff/deserialise: SYNC hunt, stuffed-zero removal, LSB-first bytes; outputs registered, 1 cycle after the input bit/EOP; no backpressure.
// SYNC hunt only when USB_DESER_SYNC_DETECT_EN is defined; otherwise the block idles in RECV after reset/EOP.
module usb_unstuff_deser (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_data,
  input  logic       i_valid,
  input  logic       i_eop,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_eop,
  output logic       o_error,
  output logic       o_active
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } state_t;

`ifdef USB_DESER_SYNC_DETECT_EN
  localparam state_t IDLE_ST = HUNT;
`else
  localparam state_t IDLE_ST = RECV;
`endif

  state_t     state_q, state_d;
  logic [2:0] ones_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic [7:0] byte_asm;

  logic take_bit, stuff_pend, data_bit, stuff_err, stuff_drop, eop_in;
  logic byte_vld_d, eop_d, err_d, active_d;

  // EOP always wins over a coincident bit, so a bit is only consumed without EOP.
  assign take_bit   = i_valid && !i_eop;
  assign stuff_pend = (ones_cnt_q == 3'd6);
  assign data_bit   = (state_q == RECV) && take_bit && !stuff_pend;
  assign stuff_err  = (state_q == RECV) && take_bit && stuff_pend && i_data;
  assign stuff_drop = (state_q == RECV) && take_bit && stuff_pend && !i_data;
  assign eop_in     = i_eop && (state_q != HUNT);

`ifdef USB_DESER_SYNC_DETECT_EN
  logic [7:0] hist_q;
  logic       sync_hit;

  // Newest bit enters at bit 0, so SYNC (seven 0s then a 1) reads as 8'h01.
  assign sync_hit = ({hist_q[6:0], i_data} == 8'h01);

  always_ff @(posedge i_clk) begin
    if (i_rst || (state_d == HUNT && state_q != HUNT)) begin
      hist_q <= 8'h00;
    end else if (state_q == HUNT && take_bit) begin
      hist_q <= {hist_q[6:0], i_data};
    end
  end
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef USB_DESER_SYNC_DETECT_EN
      HUNT: begin
        if (take_bit && sync_hit) begin
          state_d = RECV;
        end
      end
`endif
      RECV: begin
        if (i_eop) begin
          state_d = IDLE_ST;
        end else if (stuff_err) begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (i_eop) begin
          state_d = IDLE_ST;
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    byte_asm            = shreg_q;
    byte_asm[bit_cnt_q] = i_data;
    byte_vld_d          = data_bit && (bit_cnt_q == 3'd7);
    eop_d               = eop_in;
    err_d               = stuff_err || ((state_q == RECV) && i_eop && (bit_cnt_q != 3'd0));
`ifdef USB_DESER_SYNC_DETECT_EN
    active_d            = (state_d == RECV) || (state_d == ERR);
`else
    active_d            = !eop_in && (o_active || take_bit);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ones_cnt_q   <= 3'd0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_eop        <= 1'b0;
      o_error      <= 1'b0;
      o_active     <= 1'b0;
    end else begin
      o_byte_valid <= byte_vld_d;
      o_eop        <= eop_d;
      o_error      <= err_d;
      o_active     <= active_d;
      if (byte_vld_d) begin
        o_byte <= byte_asm;
      end
      if (eop_in) begin
        ones_cnt_q <= 3'd0;
        bit_cnt_q  <= 3'd0;
      end else if (data_bit) begin
        shreg_q    <= byte_asm;
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        ones_cnt_q <= i_data ? (ones_cnt_q + 3'd1) : 3'd0;
      end else if (stuff_drop) begin
        ones_cnt_q <= 3'd0;
      end
`ifdef USB_DESER_SYNC_DETECT_EN
      // SYNC's trailing 1 already counts toward the six-ones stuffing rule.
      else if (state_q == HUNT && take_bit && sync_hit) begin
        ones_cnt_q <= 3'd1;
        bit_cnt_q  <= 3'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_usb_unstuff_deser.sv
// Scoreboard bench for usb_unstuff_deser; works with or without USB_DESER_SYNC_DETECT_EN.
module tb_usb_unstuff_deser;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_data = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_eop = 1'b0;
  logic [7:0] o_byte;
  logic       o_byte_valid, o_eop, o_error, o_active;

`ifdef USB_DESER_SYNC_DETECT_EN
  localparam int SYNC_ONES = 1;
`else
  localparam int SYNC_ONES = 0;
`endif

  usb_unstuff_deser dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_eop(i_eop),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_eop(o_eop), .o_error(o_error),
    .o_active(o_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    logic       bv;
    logic [7:0] b;
    logic       eo;
    logic       er;
  } exp_t;
  exp_t sb[$];

  // Expected output for inputs driven this cycle appears in the next cycle.
  task automatic push_exp(input logic bv, input logic [7:0] b, input logic eo, input logic er);
    exp_t e;
    e.cyc = cyc + 1;
    e.bv  = bv;
    e.b   = b;
    e.eo  = eo;
    e.er  = er;
    sb.push_back(e);
  endtask

  task automatic drive(input logic d, input logic v, input logic e, input logic r);
    @(posedge clk);
    #1;
    i_data  = d;
    i_valid = v;
    i_eop   = e;
    i_rst   = r;
  endtask

  task automatic send_bit(input logic d);
    drive(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_sync();
`ifdef USB_DESER_SYNC_DETECT_EN
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i == 7) push_exp(1'b1, b, 1'b0, 1'b0);
      else repeat (int'($urandom_range(max_gap, 0))) idle();
    end
  endtask

  task automatic send_eop(input logic err);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(1'b0, 8'h00, 1'b1, err);
  endtask

  // Scoreboard monitor: every pulse must match the front entry in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (o_byte_valid !== e.bv || o_eop !== e.eo || o_error !== e.er ||
          (e.bv && o_byte !== e.b)) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d: got vld=%b byte=%h eop=%b err=%b, expected vld=%b byte=%h eop=%b err=%b",
                 cyc, o_byte_valid, o_byte, o_eop, o_error, e.bv, e.b, e.eo, e.er);
      end
    end else if (o_byte_valid !== 1'b0 || o_eop !== 1'b0 || o_error !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse cyc=%0d: got vld=%b byte=%h eop=%b err=%b, expected none",
               cyc, o_byte_valid, o_byte, o_eop, o_error);
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    n_checks += 5;
    if (o_byte !== 8'h00)     begin n_fail++; $display("FAIL reset_byte got %h expected 00", o_byte); end
    if (o_byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid got %b expected 0", o_byte_valid); end
    if (o_eop !== 1'b0)       begin n_fail++; $display("FAIL reset_eop got %b expected 0", o_eop); end
    if (o_error !== 1'b0)     begin n_fail++; $display("FAIL reset_error got %b expected 0", o_error); end
    if (o_active !== 1'b0)    begin n_fail++; $display("FAIL reset_active got %b expected 0", o_active); end
  endtask

  task automatic test_clean();
    logic [7:0] a5 = 8'hA5;
    send_sync();
    idle();
    @(negedge clk);
    n_checks++;
    if (o_active !== (SYNC_ONES == 1)) begin
      n_fail++; $display("FAIL clean_active_after_sync got %b expected %b", o_active, SYNC_ONES == 1);
    end
    send_bit(a5[0]);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_active !== 1'b1) begin n_fail++; $display("FAIL clean_active_first_bit got %b expected 1", o_active); end
    for (int i = 1; i < 8; i++) send_bit(a5[i]);
    push_exp(1'b1, 8'hA5, 1'b0, 1'b0);
    idle();
    send_eop(1'b0);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL clean_active_after_eop got %b expected 0", o_active); end
    repeat (3) idle();
    @(negedge clk);
    n_checks++;
    if (o_byte !== 8'hA5) begin n_fail++; $display("FAIL clean_byte_hold got %h expected a5", o_byte); end
  endtask

  task automatic test_stuffing();
    send_sync();
    for (int i = 0; i < 6 - SYNC_ONES; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 2 + SYNC_ONES; i++) send_bit(1'b1);
    push_exp(1'b1, 8'hFF, 1'b0, 1'b0);
    idle();
    send_eop(1'b0);
    repeat (2) idle();
  endtask

  task automatic test_stuff_error();
    send_sync();
    for (int i = 0; i < 7 - SYNC_ONES; i++) send_bit(1'b1);
    push_exp(1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_active !== 1'b1) begin n_fail++; $display("FAIL stuff_err_active_in_err got %b expected 1", o_active); end
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1, 0)));
    send_eop(1'b0);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL stuff_err_active_after_eop got %b expected 0", o_active); end
  endtask

  task automatic test_misaligned();
    send_sync();
    send_byte(8'hA5, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_eop(1'b1);
    repeat (2) idle();
  endtask

  task automatic test_collision_gaps();
    logic [7:0] a5 = 8'hA5;
    send_sync();
    for (int i = 0; i < 7; i++) begin
      send_bit(a5[i]);
      repeat (int'($urandom_range(3, 0))) idle();
    end
    drive(a5[7], 1'b1, 1'b1, 1'b0);
    push_exp(1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    n_checks++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL collision_active got %b expected 0", o_active); end
    // A bare EOP is ignored while hunting, but is a clean EOP when idling in RECV.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`ifndef USB_DESER_SYNC_DETECT_EN
    push_exp(1'b0, 8'h00, 1'b1, 1'b0);
`endif
    repeat (2) idle();
  endtask

  task automatic test_back_to_back();
    send_sync();
    send_byte(8'h5A, 0);
    send_byte(8'hC3, 0);
    send_eop(1'b0);
    repeat (2) idle();
  endtask

  task automatic test_reset_mid();
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    n_checks += 4;
    if (o_byte !== 8'h00)   begin n_fail++; $display("FAIL reset_mid_byte got %h expected 00", o_byte); end
    if (o_active !== 1'b0)  begin n_fail++; $display("FAIL reset_mid_active got %b expected 0", o_active); end
    if (o_eop !== 1'b0)     begin n_fail++; $display("FAIL reset_mid_eop got %b expected 0", o_eop); end
    if (o_error !== 1'b0)   begin n_fail++; $display("FAIL reset_mid_error got %b expected 0", o_error); end
    send_sync();
    send_byte(8'h3C, 0);
    send_eop(1'b0);
    repeat (2) idle();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuffing();
    test_stuff_error();
    test_misaligned();
    test_collision_gaps();
    test_back_to_back();
    test_reset_mid();
    repeat (5) idle();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
